// File: rtl/switchbox_cfg_pkg.sv
// Shared constants, side codes and loader state encoding for the switch-box config loader.
package switchbox_cfg_pkg;

  localparam logic [2:0] SIDE_NONE   = 3'd0;
  localparam logic [2:0] SIDE_TOP    = 3'd1;
  localparam logic [2:0] SIDE_RIGHT  = 3'd2;
  localparam logic [2:0] SIDE_BOTTOM = 3'd3;
  localparam logic [2:0] SIDE_LEFT   = 3'd4;

  localparam int WORD_W    = 6;
  localparam int NUM_WORDS = 18;
  localparam int CKSUM_W   = 8;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  typedef enum logic [1:0] {IDLE, LOAD, CHECK, COMMIT} state_t;

endpackage

// File: rtl/switchbox_cfg_loader_if.sv
// Serial config input handshake plus the active routing words driven to the switch box.
interface switchbox_cfg_loader_if #(
  parameter int NUM_TB = 5,
  parameter int NUM_LR = 4
);
  import switchbox_cfg_pkg::*;

  logic                       cfg_bit;
  logic                       cfg_valid;
  logic                       cfg_ready;
  logic                       cfg_abort;
  logic [WORD_W*NUM_TB-1:0]   cfg_top;
  logic [WORD_W*NUM_TB-1:0]   cfg_bottom;
  logic [WORD_W*NUM_LR-1:0]   cfg_left;
  logic [WORD_W*NUM_LR-1:0]   cfg_right;
  logic                       busy;
  logic                       cfg_done;
  logic                       cfg_err;

  // bitstream source side
  modport master (
    output cfg_bit, cfg_valid, cfg_abort,
    input  cfg_ready, cfg_top, cfg_bottom, cfg_left, cfg_right, busy, cfg_done, cfg_err
  );

  // loader side
  modport slave (
    input  cfg_bit, cfg_valid, cfg_abort,
    output cfg_ready, cfg_top, cfg_bottom, cfg_left, cfg_right, busy, cfg_done, cfg_err
  );

endinterface

// File: rtl/switchbox_cfg_loader_checker.sv
// Combinational range check of one routing word: side code and source index must name a real pin.
module cfg_word_checker
  import switchbox_cfg_pkg::*;
#(
  parameter int NUM_TB = 5,
  parameter int NUM_LR = 4
) (
  input  logic [WORD_W-1:0] i_word,
  output logic              o_valid
);

  localparam logic [2:0] MAX_TB = 3'(NUM_TB - 1);
  localparam logic [2:0] MAX_LR = 3'(NUM_LR - 1);

  logic [2:0] w_idx;
  logic [2:0] w_side;
  assign w_idx  = i_word[5:3];
  assign w_side = i_word[2:0];

  // hi-Z accepts any index; real sides bound the index by that edge's pin count
  always_comb begin
    o_valid = 1'b0;
    case (w_side)
      SIDE_NONE:              o_valid = 1'b1;
      SIDE_TOP, SIDE_BOTTOM:  o_valid = (w_idx <= MAX_TB);
      SIDE_RIGHT, SIDE_LEFT:  o_valid = (w_idx <= MAX_LR);
      default:                o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/switchbox_cfg_loader.sv
// Hunts the sync word, shifts a routing frame into a shadow store, validates it and commits atomically.
module switchbox_cfg_loader
  import switchbox_cfg_pkg::*;
#(
  parameter logic [7:0] SYNC_WORD = DEFAULT_SYNC,
  parameter int         NUM_TB    = 5,
  parameter int         NUM_LR    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  switchbox_cfg_loader_if.slave bus
);

  localparam int NW     = 2 * (NUM_TB + NUM_LR);
  localparam int WIDX_W = $clog2(NW);

  state_t                        r_state;
  logic [6:0]                    r_sync;     // last 7 accepted bits; the 8th is the live input
  logic [WORD_W-2:0]             r_wsh;      // partial word; the final bit is the live input
  logic [2:0]                    r_wbit;
  logic [WIDX_W-1:0]             r_widx;
  logic [NW-1:0][WORD_W-1:0]     r_shadow;
  logic [NW-1:0][WORD_W-1:0]     r_active;
  logic [CKSUM_W-1:0]            r_acc;
  logic [CKSUM_W-1:0]            r_ck;
  logic [2:0]                    r_ckcnt;
  logic                          r_rerr;
  logic                          r_ready;
  logic                          r_busy;
  logic                          r_done;
  logic                          r_err;

  logic                          w_take;
  logic [7:0]                    w_sync_nxt;
  logic [WORD_W-1:0]             w_word;
  logic                          w_word_ok;
  logic                          w_frame_ok;

  assign w_take     = bus.cfg_valid & r_ready;
  assign w_sync_nxt = {r_sync, bus.cfg_bit};
  assign w_word     = {r_wsh, bus.cfg_bit};
  assign w_frame_ok = !r_rerr && (r_ck == r_acc);

  cfg_word_checker #(.NUM_TB(NUM_TB), .NUM_LR(NUM_LR)) u_chk (
    .i_word  (w_word),
    .o_valid (w_word_ok)
  );

  // frame FSM: sync hunt, payload shift, checksum collect, atomic commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_sync   <= '0;
      r_wsh    <= '0;
      r_wbit   <= '0;
      r_widx   <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_acc    <= '0;
      r_ck     <= '0;
      r_ckcnt  <= '0;
      r_rerr   <= 1'b0;
      r_ready  <= 1'b1;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_take) begin
            if (w_sync_nxt == SYNC_WORD) begin
              // start the next hunt from a clean window so stale bits cannot alias
              r_state <= LOAD;
              r_busy  <= 1'b1;
              r_sync  <= '0;
              r_wbit  <= '0;
              r_widx  <= '0;
              r_acc   <= '0;
              r_rerr  <= 1'b0;
            end else begin
              r_sync <= w_sync_nxt[6:0];
            end
          end
        end
        LOAD: begin
          if (bus.cfg_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sync  <= '0;
          end else if (w_take) begin
            r_wsh <= w_word[WORD_W-2:0];
            if (r_wbit == 3'(WORD_W - 1)) begin
              r_wbit           <= '0;
              r_shadow[r_widx] <= w_word;
              r_acc            <= r_acc + CKSUM_W'(w_word);
              if (!w_word_ok) r_rerr <= 1'b1;
              r_widx           <= r_widx + 1'b1;
              if (r_widx == WIDX_W'(NW - 1)) begin
                r_state <= CHECK;
                r_ckcnt <= '0;
              end
            end else begin
              r_wbit <= r_wbit + 1'b1;
            end
          end
        end
        CHECK: begin
          if (bus.cfg_abort) begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_sync  <= '0;
          end else if (w_take) begin
            r_ck    <= {r_ck[CKSUM_W-2:0], bus.cfg_bit};
            r_ckcnt <= r_ckcnt + 1'b1;
            if (r_ckcnt == 3'(CKSUM_W - 1)) begin
              r_state <= COMMIT;
              r_ready <= 1'b0;
            end
          end
        end
        COMMIT: begin
          // abort is deliberately ignored here: the commit always completes
          if (w_frame_ok) begin
            r_active <= r_shadow;
            r_done   <= 1'b1;
          end else begin
            r_err <= 1'b1;
          end
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cfg_ready  = r_ready;
  assign bus.busy       = r_busy;
  assign bus.cfg_done   = r_done;
  assign bus.cfg_err    = r_err;
  assign bus.cfg_top    = r_active[NUM_TB-1:0];
  assign bus.cfg_bottom = r_active[2*NUM_TB-1:NUM_TB];
  assign bus.cfg_left   = r_active[2*NUM_TB+NUM_LR-1:2*NUM_TB];
  assign bus.cfg_right  = r_active[NW-1:2*NUM_TB+NUM_LR];

endmodule

// File: tb/tb_switchbox_cfg_loader.sv
// Randomized + directed bench for the switch-box config loader with a frame-level reference model.
module tb_switchbox_cfg_loader;
  import switchbox_cfg_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  switchbox_cfg_loader_if #(.NUM_TB(5), .NUM_LR(4)) bus();

  switchbox_cfg_loader #(.SYNC_WORD(8'hA5), .NUM_TB(5), .NUM_LR(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;
  logic gappy = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    total++;
    bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  // ---------------- reference model (frame level) ----------------
  logic [5:0] m_act [18];
  int         m_phase;          // 0 hunting, 1 collecting payload bits, 2 committing
  logic [7:0] m_win;
  logic       m_bits [116];
  int         m_n;
  logic       m_done, m_err;
  logic [5:0] md_w [18];
  int         md_sum;
  logic       md_ok;
  logic [7:0] md_ck;

  function automatic bit word_ok(input logic [5:0] w);
    int side, idx;
    side = int'(w[2:0]);
    idx  = int'(w[5:3]);
    if (side == 0) return 1'b1;
    if (side == 1 || side == 3) return idx < 5;
    if (side == 2 || side == 4) return idx < 4;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 18; i++) m_act[i] = '0;
      m_phase = 0; m_win = '0; m_n = 0; m_done = 1'b0; m_err = 1'b0;
    end else begin
      m_done = 1'b0;
      m_err  = 1'b0;
      if (m_phase == 2) begin
        md_sum = 0; md_ok = 1'b1; md_ck = '0;
        for (int i = 0; i < 18; i++) begin
          md_w[i] = '0;
          for (int b = 0; b < 6; b++) md_w[i] = {md_w[i][4:0], m_bits[6*i+b]};
          md_sum += int'(md_w[i]);
          if (!word_ok(md_w[i])) md_ok = 1'b0;
        end
        for (int b = 0; b < 8; b++) md_ck = {md_ck[6:0], m_bits[108+b]};
        if (md_ok && int'(md_ck) == md_sum % 256) begin
          for (int i = 0; i < 18; i++) m_act[i] = md_w[i];
          m_done = 1'b1;
        end else begin
          m_err = 1'b1;
        end
        m_phase = 0;
      end else if (m_phase == 1) begin
        if (bus.cfg_abort) begin
          m_phase = 0; m_win = '0;
        end else if (bus.cfg_valid) begin
          m_bits[m_n] = bus.cfg_bit;
          m_n++;
          if (m_n == 116) m_phase = 2;
        end
      end else if (bus.cfg_valid) begin
        m_win = {m_win[6:0], bus.cfg_bit};
        if (m_win == 8'hA5) begin
          m_phase = 1; m_n = 0; m_win = '0;
        end
      end
    end
  end

  function automatic logic [29:0] pack(input logic [5:0] a [18], input int base, input int n);
    logic [29:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[6*i +: 6] = a[base+i];
    return v;
  endfunction

  // per-cycle compare against the model, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chk("top",    32'(bus.cfg_top),    32'(pack(m_act, 0, 5)));
      chk("bottom", 32'(bus.cfg_bottom), 32'(pack(m_act, 5, 5)));
      chk("left",   32'(bus.cfg_left),   32'(pack(m_act, 10, 4)));
      chk("right",  32'(bus.cfg_right),  32'(pack(m_act, 14, 4)));
      chk("busy",   32'(bus.busy),       32'(m_phase != 0));
      chk("ready",  32'(bus.cfg_ready),  32'(m_phase != 2));
      chk("done",   32'(bus.cfg_done),   32'(m_done));
      chk("err",    32'(bus.cfg_err),    32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  logic [5:0] w [18];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_bit(input logic b, input bit allow_gap);
    logic r;
    int   waitc;
    waitc = 0;
    bus.cfg_bit   = b;
    bus.cfg_valid = 1'b1;
    forever begin
      r = bus.cfg_ready;
      tick();
      if (r) break;
      waitc++;
      if (waitc > 8) begin fail_now("ready_timeout"); break; end
    end
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'($urandom);
    if (gappy && allow_gap) repeat ($urandom_range(0, 2)) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i], 1'b1);
  endtask

  // sync + payload + checksum; stops after stop_after payload bits when < 116
  task automatic send_frame(input logic [5:0] fw [18], input logic [7:0] ck, input int stop_after);
    int n;
    n = 0;
    send_byte(8'hA5);
    for (int i = 0; i < 18; i++)
      for (int b = 5; b >= 0; b--) begin
        if (n == stop_after) return;
        send_bit(fw[i][b], 1'b1);
        n++;
      end
    for (int b = 7; b >= 0; b--) begin
      if (n == stop_after) return;
      send_bit(ck[b], b != 0);
      n++;
    end
  endtask

  function automatic logic [7:0] cksum(input logic [5:0] fw [18]);
    logic [7:0] s;
    s = '0;
    for (int i = 0; i < 18; i++) s = s + {2'b00, fw[i]};
    return s;
  endfunction

  function automatic logic [5:0] rand_word();
    int side, idx;
    side = $urandom_range(0, 4);
    if (side == 0) idx = $urandom_range(0, 7);
    else if (side == 1 || side == 3) idx = $urandom_range(0, 4);
    else idx = $urandom_range(0, 3);
    return {3'(idx), 3'(side)};
  endfunction

  task automatic clear_w();
    for (int i = 0; i < 18; i++) w[i] = '0;
  endtask

  // last checksum bit was just accepted: result must appear one edge later
  task automatic expect_result(input string nm, input logic exp_done);
    tick();
    chk({nm, "_done"}, 32'(bus.cfg_done), 32'(exp_done));
    chk({nm, "_err"},  32'(bus.cfg_err),  32'(!exp_done));
  endtask

  initial begin
    #1_000_000;
    fail_now("global_timeout");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  initial begin
    bus.cfg_bit = 1'b0; bus.cfg_valid = 1'b0; bus.cfg_abort = 1'b0;
    #12;
    chk("rst_top",   32'(bus.cfg_top), 32'h0);
    chk("rst_right", 32'(bus.cfg_right), 32'h0);
    chk("rst_ready", 32'(bus.cfg_ready), 32'h1);
    chk("rst_busy",  32'(bus.busy), 32'h0);
    chk("rst_pulse", 32'({bus.cfg_done, bus.cfg_err}), 32'h0);
    tick();
    rst_n = 1'b1;
    repeat (20) tick();

    // top[0] = right pin 1, checksum 0x0A
    clear_w(); w[0] = 6'h0A;
    send_frame(w, 8'h0A, 999);
    expect_result("frameA", 1'b1);
    chk("frameA_top", 32'(bus.cfg_top), 32'h0A);
    chk("frameA_left", 32'(bus.cfg_left), 32'h0);

    send_frame(w, 8'h0B, 999);
    expect_result("badck", 1'b0);
    chk("badck_top", 32'(bus.cfg_top), 32'h0A);

    clear_w(); w[13] = 6'b101_001;
    send_frame(w, 8'h29, 999);
    expect_result("range_tb", 1'b0);
    chk("range_tb_top", 32'(bus.cfg_top), 32'h0A);
    chk("range_tb_left", 32'(bus.cfg_left), 32'h0);

    clear_w(); w[13] = 6'b000_111;
    send_frame(w, 8'h07, 999);
    expect_result("side7", 1'b0);

    // junk ahead of the frame (LSB first so no 8-bit window aliases the sync word)
    gappy = 1'b1;
    for (int i = 0; i < 8; i++) send_bit(1'((8'h52 >> i) & 1), 1'b1);
    for (int i = 0; i < 18; i++) w[i] = rand_word();
    send_frame(w, cksum(w), 999);
    expect_result("junk", 1'b1);
    chk("junk_right", 32'(bus.cfg_right), 32'(pack(w, 14, 4)));
    gappy = 1'b0;

    // aborted frame followed by a good one
    clear_w(); w[5] = 6'h0B;
    send_frame(w, cksum(w), 50);
    bus.cfg_abort = 1'b1; tick(); bus.cfg_abort = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'h0);
    for (int i = 0; i < 18; i++) w[i] = rand_word();
    w[10] = 6'b011_100;
    send_frame(w, cksum(w), 999);
    expect_result("post_abort", 1'b1);
    chk("post_abort_left", 32'(bus.cfg_left), 32'(pack(w, 10, 4)));

    // randomized frames: bad words, bad checksums, aborts, valid gaps
    for (int f = 0; f < 25; f++) begin
      logic [7:0] ck;
      int stop;
      gappy = 1'($urandom);
      for (int i = 0; i < 18; i++) w[i] = rand_word();
      if ($urandom_range(0, 4) == 0) w[$urandom_range(0, 17)] = {3'($urandom_range(5, 7)), 3'd1};
      if ($urandom_range(0, 4) == 0) w[$urandom_range(0, 17)] = {3'($urandom), 3'($urandom_range(5, 7))};
      ck = cksum(w);
      if ($urandom_range(0, 4) == 0) ck = ck ^ 8'(1 << $urandom_range(0, 7));
      stop = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 115) : 999;
      send_frame(w, ck, stop);
      if (stop < 116) begin
        bus.cfg_abort = 1'b1; tick(); bus.cfg_abort = 1'b0;
      end
      repeat ($urandom_range(0, 3)) tick();
    end
    gappy = 1'b0;
    repeat (3) tick();

    // abort during COMMIT is ignored
    for (int i = 0; i < 18; i++) w[i] = rand_word();
    w[0] = 6'h0A;
    send_frame(w, cksum(w), 999);
    bus.cfg_abort = 1'b1;
    expect_result("commit_abort", 1'b1);
    bus.cfg_abort = 1'b0;
    chk("commit_abort_top", 32'(bus.cfg_top), 32'(pack(w, 0, 5)));

    // async reset in the middle of the checksum
    send_frame(w, cksum(w), 111);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_top",   32'(bus.cfg_top), 32'h0);
    chk("midrst_bot",   32'(bus.cfg_bottom), 32'h0);
    chk("midrst_busy",  32'(bus.busy), 32'h0);
    chk("midrst_ready", 32'(bus.cfg_ready), 32'h1);
    tick();
    rst_n = 1'b1;
    tick();

    clear_w(); w[17] = 6'b001_100;
    send_frame(w, cksum(w), 999);
    expect_result("recover", 1'b1);
    chk("recover_right", 32'(bus.cfg_right), 32'(6'b001_100) << 18);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
